// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Decode-side handshake bundle for the hazard/bypass controller.
//               Carries the decode operand/destination description and the
//               redirect strobe in, and the stall/kill/forwarding results out.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int NSTAGES = 2,
    parameter int REGW    = 5,
    parameter int CNTW    = 32
);
    // Forwarding code width: enough to encode 0 (regfile) .. NSTAGES.
    localparam int c_fw = $clog2(NSTAGES + 1);

    logic            id_valid;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [REGW-1:0] id_rd;
    logic            id_we;
    logic            id_is_load;
    logic            ex_redirect;

    logic            stall;
    logic            kill;
    logic [c_fw-1:0] fwd_a;
    logic [c_fw-1:0] fwd_b;
    logic [CNTW-1:0] stall_cnt;

    // Pipeline control side: describes the decode slot, consumes decisions.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_we, id_is_load, ex_redirect,
        input  stall, kill, fwd_a, fwd_b, stall_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_we, id_is_load, ex_redirect,
        output stall, kill, fwd_a, fwd_b, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Parametrised hazard and bypass controller. Tracks destination
//               registers of the NSTAGES instructions ahead of decode, emits
//               registered forwarding codes, a combinational load-use stall,
//               a multi-cycle kill window after a redirect and a saturating
//               stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NSTAGES     = 2,
    parameter int LOAD_DIST   = 2,
    parameter int KILL_CYCLES = 1,
    parameter int REGW        = 5,
    parameter int CNTW        = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    hazard_ctrl_if.slave  bus
);
    // Forwarding code width and kill counter width.
    localparam int c_fw = $clog2(NSTAGES + 1);
    localparam int c_kw = $clog2(KILL_CYCLES + 1);

    localparam logic [c_kw-1:0] c_kill_load = c_kw'(KILL_CYCLES);
    localparam logic [c_kw-1:0] c_kill_one  = c_kw'(1);
    localparam logic [CNTW-1:0] c_cnt_one   = CNTW'(1);

    // ------------------------------------------------------------------
    // In-flight tracker. Index 1 is the instruction now in X, index k is
    // k stages ahead of decode. A bubble is stored with every field clear.
    // ------------------------------------------------------------------
    logic            r_v  [1:NSTAGES];
    logic [REGW-1:0] r_rd [1:NSTAGES];
    logic            r_we [1:NSTAGES];
    logic            r_ld [1:NSTAGES];

    logic [c_kw-1:0] r_kc;
    logic [c_fw-1:0] r_fwd_a;
    logic [c_fw-1:0] r_fwd_b;
    logic [CNTW-1:0] r_cnt;

    logic [NSTAGES:1] w_match_a;
    logic [NSTAGES:1] w_match_b;
    logic [c_fw-1:0]  w_dist_a;
    logic [c_fw-1:0]  w_dist_b;
    logic             w_lduse_a;
    logic             w_lduse_b;
    logic             w_kill;
    logic             w_stall;
    logic             w_issue;

    // Per-entry producer match for each operand. x0 is never a dependency,
    // and an unread operand never creates one.
    generate
        for (genvar k = 1; k <= NSTAGES; k++) begin : g_match
            assign w_match_a[k] = bus.id_rs1_used && r_v[k] && r_we[k] &&
                                  (r_rd[k] == bus.id_rs1) && (bus.id_rs1 != '0);
            assign w_match_b[k] = bus.id_rs2_used && r_v[k] && r_we[k] &&
                                  (r_rd[k] == bus.id_rs2) && (bus.id_rs2 != '0);
        end
    endgenerate

    // Youngest-match priority pick: scan oldest to youngest so the nearest
    // producer overwrites. A load match too close to be forwardable flags a
    // load-use hazard.
    always_comb begin
        w_dist_a  = '0;
        w_dist_b  = '0;
        w_lduse_a = 1'b0;
        w_lduse_b = 1'b0;
        for (int k = NSTAGES; k >= 1; k--) begin
            if (w_match_a[k]) begin
                w_dist_a  = c_fw'(k);
                w_lduse_a = r_ld[k] && (k < LOAD_DIST);
            end
            if (w_match_b[k]) begin
                w_dist_b  = c_fw'(k);
                w_lduse_b = r_ld[k] && (k < LOAD_DIST);
            end
        end
    end

    // Kill is a pure function of the counter register, so it carries no
    // combinational path from the decode inputs.
    assign w_kill = (r_kc != '0);

    // A redirect or an active kill window squashes decode, so neither can
    // coexist with a stall; stall is also held low while reset is asserted.
    assign w_stall = reset && bus.id_valid && !w_kill && !bus.ex_redirect &&
                     (w_lduse_a || w_lduse_b);

    assign w_issue = bus.id_valid && !w_stall && !w_kill && !bus.ex_redirect;

    // Tracker shift: decode enters slot 1 on issue, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= NSTAGES; k++) begin
                r_v[k]  <= 1'b0;
                r_rd[k] <= '0;
                r_we[k] <= 1'b0;
                r_ld[k] <= 1'b0;
            end
        end else begin
            r_v[1]  <= w_issue;
            r_rd[1] <= w_issue ? bus.id_rd : '0;
            r_we[1] <= w_issue && bus.id_we;
            r_ld[1] <= w_issue && bus.id_is_load;
            for (int k = 2; k <= NSTAGES; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
                r_we[k] <= r_we[k-1];
                r_ld[k] <= r_ld[k-1];
            end
        end
    end

    // Forwarding codes for the instruction entering X; a bubble reads regfile.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else begin
            r_fwd_a <= w_issue ? w_dist_a : '0;
            r_fwd_b <= w_issue ? w_dist_b : '0;
        end
    end

    // Kill window counter: a redirect (re)loads the full window, otherwise
    // it drains one slot per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_kc <= '0;
        end else if (bus.ex_redirect) begin
            r_kc <= c_kill_load;
        end else if (r_kc != '0) begin
            r_kc <= r_kc - c_kill_one;
        end
    end

    // Saturating stall-cycle counter for performance CSRs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.kill      = w_kill;
    assign bus.fwd_a     = r_fwd_a;
    assign bus.fwd_b     = r_fwd_b;
    assign bus.stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Three configurations:
//               dut0 defaults, dut1 NSTAGES=3/LOAD_DIST=3/KILL_CYCLES=2,
//               dut2 defaults with a 2-bit stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rstn;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       redir;
    } stim_t;

    typedef struct packed {
        logic        kill;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } regexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur;
    logic  rst_n;
    assign rst_n = cur.rstn;

    hazard_ctrl_if #(.NSTAGES(2), .REGW(5), .CNTW(32)) bus0 ();
    hazard_ctrl_if #(.NSTAGES(3), .REGW(5), .CNTW(32)) bus1 ();
    hazard_ctrl_if #(.NSTAGES(2), .REGW(5), .CNTW(2))  bus2 ();

    assign {bus0.id_valid, bus0.id_rs1, bus0.id_rs1_used, bus0.id_rs2, bus0.id_rs2_used,
            bus0.id_rd, bus0.id_we, bus0.id_is_load, bus0.ex_redirect} =
           {cur.valid, cur.rs1, cur.u1, cur.rs2, cur.u2, cur.rd, cur.we, cur.ld, cur.redir};
    assign {bus1.id_valid, bus1.id_rs1, bus1.id_rs1_used, bus1.id_rs2, bus1.id_rs2_used,
            bus1.id_rd, bus1.id_we, bus1.id_is_load, bus1.ex_redirect} =
           {cur.valid, cur.rs1, cur.u1, cur.rs2, cur.u2, cur.rd, cur.we, cur.ld, cur.redir};
    assign {bus2.id_valid, bus2.id_rs1, bus2.id_rs1_used, bus2.id_rs2, bus2.id_rs2_used,
            bus2.id_rd, bus2.id_we, bus2.id_is_load, bus2.ex_redirect} =
           {cur.valid, cur.rs1, cur.u1, cur.rs2, cur.u2, cur.rd, cur.we, cur.ld, cur.redir};

    hazard_ctrl #(.NSTAGES(2), .LOAD_DIST(2), .KILL_CYCLES(1), .REGW(5), .CNTW(32)) dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0));
    hazard_ctrl #(.NSTAGES(3), .LOAD_DIST(3), .KILL_CYCLES(2), .REGW(5), .CNTW(32)) dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1));
    hazard_ctrl #(.NSTAGES(2), .LOAD_DIST(2), .KILL_CYCLES(1), .REGW(5), .CNTW(2)) dut2 (
        .clk(clk), .reset(rst_n), .bus(bus2));

    // Observed outputs of the configuration under test.
    int      sel;
    logic    obs_stall;
    regexp_t obs_reg;
    always_comb begin
        case (sel)
            1: begin
                obs_stall = bus1.stall;
                obs_reg   = {bus1.kill, bus1.fwd_a, bus1.fwd_b, bus1.stall_cnt};
            end
            2: begin
                obs_stall = bus2.stall;
                obs_reg   = {bus2.kill, bus2.fwd_a, bus2.fwd_b, 30'b0, bus2.stall_cnt};
            end
            default: begin
                obs_stall = bus0.stall;
                obs_reg   = {bus0.kill, bus0.fwd_a, bus0.fwd_b, bus0.stall_cnt};
            end
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Per-test plan and the scoreboard of pending registered expectations.
    stim_t   plan_s[$];
    logic    plan_stall[$];
    regexp_t plan_r[$];
    regexp_t sb_q[$];

    function automatic stim_t mk(input int rstn, input int valid, input int rs1, input int u1,
                                 input int rs2, input int u2, input int rd, input int we,
                                 input int ld, input int redir);
        stim_t s;
        s.rstn  = 1'(rstn);
        s.valid = 1'(valid);
        s.rs1   = 5'(rs1);
        s.u1    = 1'(u1);
        s.rs2   = 5'(rs2);
        s.u2    = 1'(u2);
        s.rd    = 5'(rd);
        s.we    = 1'(we);
        s.ld    = 1'(ld);
        s.redir = 1'(redir);
        return s;
    endfunction

    function automatic regexp_t ex(input int kill, input int fa, input int fb, input int cnt);
        regexp_t r;
        r.kill = 1'(kill);
        r.fa   = 2'(fa);
        r.fb   = 2'(fb);
        r.cnt  = 32'(cnt);
        return r;
    endfunction

    task automatic plan_clear();
        plan_s.delete();
        plan_stall.delete();
        plan_r.delete();
    endtask

    task automatic add_row(input stim_t s, input int st, input regexp_t r);
        plan_s.push_back(s);
        plan_stall.push_back(1'(st));
        plan_r.push_back(r);
    endtask

    // Reset row and idle/redirect rows used throughout.
    function automatic stim_t RST();  return mk(0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic stim_t IDLE(); return mk(1,0,0,0,0,0,0,0,0,0); endfunction
    function automatic stim_t RDR();  return mk(1,0,0,0,0,0,0,0,0,1); endfunction

    task automatic test_reset();
        regexp_t got, want;
        sel = 0; plan_clear();
        add_row(mk(0,1,7,1,7,1,8,1,0,0), 0, ex(0,0,0,0));
        add_row(IDLE(),                  0, ex(0,0,0,0));
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL reset row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        regexp_t got, want;
        sel = 0; plan_clear();
        add_row(RST(),                     0, ex(0,0,0,0));
        add_row(mk(1,1,1,1,2,1,5,1,0,0),   0, ex(0,0,0,0));   // add x5,x1,x2
        add_row(mk(1,1,5,1,1,1,6,1,0,0),   0, ex(0,1,0,0));   // add x6,x5,x1
        add_row(mk(1,1,5,1,6,1,7,1,0,0),   0, ex(0,2,1,0));   // add x7,x5,x6
        add_row(IDLE(),                    0, ex(0,0,0,0));
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL back_to_back row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL back_to_back row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        regexp_t got, want;
        sel = 0; plan_clear();
        add_row(RST(),                     0, ex(0,0,0,0));
        add_row(mk(1,1,2,1,0,0,7,1,1,0),   0, ex(0,0,0,0));   // lw x7
        add_row(mk(1,1,7,1,7,1,8,1,0,0),   1, ex(0,0,0,1));   // add x8,x7,x7 stalls
        add_row(mk(1,1,7,1,7,1,8,1,0,0),   0, ex(0,2,2,1));   // forwarded from d=2
        add_row(IDLE(),                    0, ex(0,0,0,1));
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL load_use row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL load_use row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_youngest();
        regexp_t got, want;
        sel = 0; plan_clear();
        add_row(RST(),                     0, ex(0,0,0,0));
        add_row(mk(1,1,0,1,0,0,9,1,0,0),   0, ex(0,0,0,0));   // addi x9
        add_row(mk(1,1,0,1,0,0,9,1,0,0),   0, ex(0,0,0,0));   // addi x9 again
        add_row(mk(1,1,9,1,3,1,10,1,0,0),  0, ex(0,1,0,0));   // youngest x9 wins
        add_row(mk(1,1,0,0,0,0,0,1,0,0),   0, ex(0,0,0,0));   // writes x0
        add_row(mk(1,1,0,1,0,1,12,1,0,0),  0, ex(0,0,0,0));   // reads x0: regfile
        add_row(mk(1,1,0,0,0,0,11,0,0,0),  0, ex(0,0,0,0));   // rd=x11, no write
        add_row(mk(1,1,11,1,12,1,13,1,0,0),0, ex(0,0,2,0));   // x11 not written, x12 at d=2
        add_row(mk(1,1,13,0,13,0,14,1,0,0),0, ex(0,0,0,0));   // operands unused
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL youngest row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL youngest row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_redirect_stall();
        regexp_t got, want;
        sel = 0; plan_clear();
        add_row(RST(),                     0, ex(0,0,0,0));
        add_row(mk(1,1,2,1,0,0,7,1,1,0),   0, ex(0,0,0,0));   // lw x7
        add_row(mk(1,1,7,1,7,1,8,1,0,1),   0, ex(1,0,0,0));   // load-use + redirect
        add_row(mk(1,1,7,1,7,1,8,1,0,0),   0, ex(0,0,0,0));   // squashed slot
        add_row(mk(1,1,7,1,7,1,8,1,0,0),   0, ex(0,0,0,0));   // load long gone
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL redirect_stall row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL redirect_stall row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_kill();
        regexp_t got, want;
        sel = 1; plan_clear();
        add_row(RST(),                     0, ex(0,0,0,0));
        add_row(mk(1,1,0,0,0,0,5,1,0,0),   0, ex(0,0,0,0));   // producer x5
        add_row(mk(1,1,5,1,0,0,6,1,0,1),   0, ex(1,0,0,0));   // redirect
        add_row(mk(1,1,5,1,0,0,6,1,0,0),   0, ex(1,0,0,0));   // killed slot 1
        add_row(mk(1,1,5,1,0,0,6,1,0,0),   0, ex(0,0,0,0));   // killed slot 2
        add_row(mk(1,1,5,1,0,0,6,1,0,0),   0, ex(0,0,0,0));   // x5 dropped off
        add_row(RDR(),                     0, ex(1,0,0,0));
        add_row(IDLE(),                    0, ex(1,0,0,0));
        add_row(RDR(),                     0, ex(1,0,0,0));   // re-arm mid window
        add_row(IDLE(),                    0, ex(1,0,0,0));
        add_row(IDLE(),                    0, ex(0,0,0,0));
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL kill row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL kill row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_deep_reset();
        regexp_t got, want;
        sel = 1; plan_clear();
        add_row(RST(),                     0, ex(0,0,0,0));
        add_row(mk(1,1,2,1,0,0,7,1,1,0),   0, ex(0,0,0,0));   // lw x7
        add_row(IDLE(),                    0, ex(0,0,0,0));
        add_row(mk(1,1,7,1,0,0,8,1,0,0),   1, ex(0,0,0,1));   // load at d=2 stalls
        add_row(mk(1,1,7,1,0,0,8,1,0,0),   0, ex(0,3,0,1));   // load at d=3 forwards
        add_row(RDR(),                     0, ex(1,0,0,1));
        add_row(mk(0,1,8,1,0,0,9,1,0,0),   0, ex(0,0,0,0));   // reset during kill
        add_row(mk(1,1,2,1,0,0,7,1,1,0),   0, ex(0,0,0,0));   // lw x7
        add_row(mk(0,1,7,1,0,0,8,1,0,0),   0, ex(0,0,0,0));   // reset masks stall
        add_row(mk(1,1,7,1,0,0,8,1,0,0),   0, ex(0,0,0,0));   // tracker empty
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL deep_reset row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL deep_reset row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    task automatic test_saturate();
        regexp_t got, want;
        sel = 2; plan_clear();
        add_row(RST(), 0, ex(0,0,0,0));
        for (int it = 0; it < 4; it++) begin
            add_row(mk(1,1,0,0,0,0,7,1,1,0), 0, ex(0,0,0,(it < 3) ? it : 3));
            add_row(mk(1,1,7,1,0,0,8,1,0,0), 1, ex(0,0,0,(it + 1 < 3) ? it + 1 : 3));
            add_row(mk(1,1,7,1,0,0,8,1,0,0), 0, ex(0,2,0,(it + 1 < 3) ? it + 1 : 3));
        end
        for (int i = 0; i < plan_s.size(); i++) begin
            cur = plan_s[i];
            #2;
            n_cmp++;
            if (obs_stall !== plan_stall[i]) begin
                n_bad++;
                $display("FAIL saturate row %0d stall: got %b want %b", i, obs_stall, plan_stall[i]);
            end
            sb_q.push_back(plan_r[i]);
            @(posedge clk); #1;
            got = obs_reg; want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL saturate row %0d regs: got kill=%b fa=%0d fb=%0d cnt=%0d want kill=%b fa=%0d fb=%0d cnt=%0d",
                         i, got.kill, got.fa, got.fb, got.cnt, want.kill, want.fa, want.fb, want.cnt);
            end
        end
    endtask

    initial begin
        sel = 0;
        cur = RST();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest();
        test_redirect_stall();
        test_kill();
        test_deep_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
